conv_dot_engine: RTL and testbench

//  Parametrised multi-lane dot-product engine for the convolution datapath.

---
 rtl/conv_dot_engine_pkg.sv | 23 ++
 rtl/conv_dot_engine_if.sv | 32 +++
 rtl/conv_dot_engine_lane_mul.sv | 78 +++++++
 rtl/conv_dot_engine.sv | 136 +++++++++++++
 tb/tb_conv_dot_engine.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_dot_engine_pkg.sv
// Shared types and sizing helpers for the convolution dot-product engine.
//   state_e  : engine control states
//   BEAT_W   : width of the accumulated-beat counter
//   acc_w()  : accumulator width from operand width, lane count and guard bits
package conv_dot_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int unsigned BEAT_W = 16;

  // Full-precision lane product plus room for the lane sum and multi-beat growth.
  function automatic int unsigned acc_w(input int unsigned width,
                                        input int unsigned len,
                                        input int unsigned guard);
    return 2 * width + int'($clog2(len)) + guard;
  endfunction

endpackage

// File: rtl/conv_dot_engine_if.sv
// Beat-in / result-out handshake bundle of the dot-product engine.
//   master : producer/consumer side (drives beats, accepts results)
//   slave  : engine side
interface conv_dot_engine_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = conv_dot_engine_pkg::acc_w(64, 4, 8)
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LEN*WIDTH-1:0]   in_kernel;
  logic [LEN*WIDTH-1:0]   in_data;
  logic                   in_last;
  logic                   in_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_result;
  logic [conv_dot_engine_pkg::BEAT_W-1:0] out_beats;
  logic                   out_overflow;

  modport master (
    output in_valid, in_kernel, in_data, in_last, in_signed, out_ready,
    input  in_ready, out_valid, out_result, out_beats, out_overflow
  );

  modport slave (
    input  in_valid, in_kernel, in_data, in_last, in_signed, out_ready,
    output in_ready, out_valid, out_result, out_beats, out_overflow
  );

endinterface

// File: rtl/conv_dot_engine_lane_mul.sv
// Iterative shift-add multiplier for one lane.
//   clk, rst   : clock, async active-high reset
//   start      : one-cycle pulse; samples a, b, is_signed
//   is_signed  : treat a/b as two's complement
//   a, b       : WIDTH-bit operands
//   finish     : high once the product is final, held until the next start
//   product    : 2*WIDTH-bit product (valid while finish is high)
// Magnitudes are multiplied and the sign is applied on the last step. The
// first partial product is taken on the start edge, so the result is final
// WIDTH-1 edges after start is sampled.
module conv_dot_engine_lane_mul #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 finish,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [PW-1:0]    step_c;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_r;
  logic             busy_r;

  // Operand magnitudes and the next partial-sum step.
  always_comb begin
    a_mag_c = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    b_mag_c = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    step_c  = acc_r + (mplier_r[0] ? mcand_r : '0);
  end

  // Load on start, then one shift-add step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      finish   <= 1'b0;
    end else if (start) begin
      acc_r    <= b_mag_c[0] ? PW'(a_mag_c) : '0;
      mcand_r  <= PW'(a_mag_c) << 1;
      mplier_r <= b_mag_c >> 1;
      cnt_r    <= CW'(1);
      neg_r    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      busy_r   <= 1'b1;
      finish   <= 1'b0;
    end else if (busy_r) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      if (cnt_r == CW'(WIDTH - 1)) begin
        acc_r  <= neg_r ? (~step_c) + PW'(1) : step_c;
        busy_r <= 1'b0;
        finish <= 1'b1;
      end else begin
        acc_r  <= step_c;
      end
    end
  end

  assign product = acc_r;

endmodule

// File: rtl/conv_dot_engine.sv
// Multi-lane dot-product engine: LEN lane multipliers per beat, lane products
// summed into an accumulator across beats until the last beat.
//   clk, rst : clock, async active-high reset
//   bus      : conv_dot_engine_if.slave (beat input, result output)
// Result fields come straight from the accumulator/counter registers.
module conv_dot_engine
  import conv_dot_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LEN   = 4,
  parameter int unsigned GUARD = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv_dot_engine_if.slave bus
);

  localparam int unsigned ACC_W = acc_w(WIDTH, LEN, GUARD);
  localparam int unsigned VEC_W = LEN * WIDTH;
  localparam int unsigned PW    = 2 * WIDTH;

  state_e            state;
  logic [VEC_W-1:0]  k_r;
  logic [VEC_W-1:0]  d_r;
  logic              last_r;
  logic              mode_r;
  logic              first_r;
  logic              start_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              ovf_r;
  logic [ACC_W-1:0]  acc_r;
  logic [BEAT_W-1:0] beats_r;

  logic [LEN-1:0]    lane_done;
  logic [PW-1:0]     lane_prod [LEN];
  logic [ACC_W-1:0]  sum_c;
  logic [ACC_W:0]    add_c;
  logic              wrap_c;

  // Lane multipliers run in lockstep off a shared start pulse.
  for (genvar i = 0; i < LEN; i++) begin : g_lane
    conv_dot_engine_lane_mul #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .start     (start_r),
      .is_signed (mode_r),
      .a         (k_r[i*WIDTH +: WIDTH]),
      .b         (d_r[i*WIDTH +: WIDTH]),
      .finish    (lane_done[i]),
      .product   (lane_prod[i])
    );
  end

  // Lane sum and accumulate; sign extension subtracts 2^PW for negative products.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LEN; i++) begin
      sum_c = sum_c + ACC_W'(lane_prod[i])
            - ((mode_r && lane_prod[i][PW-1]) ? (ACC_W'(1) << PW) : '0);
    end
    add_c  = {1'b0, acc_r} + {1'b0, sum_c};
    wrap_c = mode_r ? ((acc_r[ACC_W-1] == sum_c[ACC_W-1]) &&
                       (add_c[ACC_W-1] != acc_r[ACC_W-1]))
                    : add_c[ACC_W];
  end

  // Control FSM with registered handshake and result state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_r         <= '0;
      d_r         <= '0;
      last_r      <= 1'b0;
      mode_r      <= 1'b0;
      first_r     <= 1'b1;
      start_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      acc_r       <= '0;
      beats_r     <= '0;
    end else begin
      start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            k_r        <= bus.in_kernel;
            d_r        <= bus.in_data;
            last_r     <= bus.in_last;
            if (first_r) mode_r <= bus.in_signed;
            first_r    <= 1'b0;
            start_r    <= 1'b1;
            in_ready_r <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          // Finish flags from the previous op are still high while start is in flight.
          if (!start_r && (&lane_done)) state <= ACC;
        end
        ACC: begin
          acc_r   <= add_c[ACC_W-1:0];
          beats_r <= (beats_r == '1) ? beats_r : beats_r + BEAT_W'(1);
          ovf_r   <= ovf_r | wrap_c;
          if (last_r) begin
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else begin
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_r       <= '0;
            beats_r     <= '0;
            ovf_r       <= 1'b0;
            first_r     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_result   = acc_r;
  assign bus.out_beats    = beats_r;
  assign bus.out_overflow = ovf_r;

endmodule

// File: tb/tb_conv_dot_engine.sv
// Directed bench for conv_dot_engine: WIDTH=8, LEN=4 with GUARD=4 (dut A)
// and GUARD=0 (dut B, 18-bit accumulator).
module tb_conv_dot_engine;

  localparam int unsigned ACC_A = 22;
  localparam int unsigned ACC_B = 18;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  conv_dot_engine_if #(.WIDTH(8), .LEN(4), .ACC_W(ACC_A)) ifa ();
  conv_dot_engine_if #(.WIDTH(8), .LEN(4), .ACC_W(ACC_B)) ifb ();

  conv_dot_engine #(.WIDTH(8), .LEN(4), .GUARD(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  conv_dot_engine #(.WIDTH(8), .LEN(4), .GUARD(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] k;
    logic [31:0] d;
    logic        sgn;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present one beat on dut A and let it be accepted on the next rising edge.
  task automatic beat_a(input logic [31:0] k, input logic [31:0] d,
                        input logic last, input logic sgn);
    @(negedge clk);
    chk("a_ready_before_beat", 64'(ifa.in_ready), 64'd1);
    ifa.in_kernel = k;
    ifa.in_data   = d;
    ifa.in_last   = last;
    ifa.in_signed = sgn;
    ifa.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    ifa.in_valid  = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] k, input logic [31:0] d,
                        input logic last, input logic sgn);
    @(negedge clk);
    chk("b_ready_before_beat", 64'(ifb.in_ready), 64'd1);
    ifb.in_kernel = k;
    ifb.in_data   = d;
    ifb.in_last   = last;
    ifb.in_signed = sgn;
    ifb.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    ifb.in_valid  = 1'b0;
  endtask

  // Edges from accept until dut A raises out_valid (sel=1) or in_ready (sel=0).
  task automatic wait_a(input logic sel, output int cyc);
    cyc = 0;
    while (!(sel ? ifa.out_valid : ifa.in_ready) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_b(input logic sel, output int cyc);
    cyc = 0;
    while (!(sel ? ifb.out_valid : ifb.in_ready) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic handshake_a();
    @(negedge clk);
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b0;
    chk("a_hs_in_ready",  64'(ifa.in_ready),  64'd1);
    chk("a_hs_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("a_hs_cleared",   64'(ifa.out_result), 64'd0);
  endtask

  task automatic handshake_b();
    @(negedge clk);
    ifb.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifb.out_ready = 1'b0;
    chk("b_hs_in_ready",  64'(ifb.in_ready),  64'd1);
    chk("b_hs_out_valid", 64'(ifb.out_valid), 64'd0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_in_ready"},  64'(ifa.in_ready),     64'd1);
    chk({tag, "_out_valid"}, 64'(ifa.out_valid),    64'd0);
    chk({tag, "_result"},    64'(ifa.out_result),   64'd0);
    chk({tag, "_beats"},     64'(ifa.out_beats),    64'd0);
    chk({tag, "_overflow"},  64'(ifa.out_overflow), 64'd0);
  endtask

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;

    // Lane 0 is the low byte: K={1,2,3,4} packs as 32'h04030201.
    vecs[0] = '{32'h04030201, 32'h08070605, 1'b0, 64'd70,       "u_1234x5678"};
    vecs[1] = '{32'h04FD02FF, 32'h08070605, 1'b1, 64'd18,       "s_mixed"};
    vecs[2] = '{32'h80808080, 32'h80808080, 1'b1, 64'd65536,    "s_min_sq"};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'd260100,   "u_max_sq"};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd4,        "s_neg1_sq"};
    vecs[5] = '{32'hFFFFFFFF, 32'h01010101, 1'b1, 64'h3FFFFC,   "s_neg_sum"};
    vecs[6] = '{32'h00000000, 32'h12345678, 1'b0, 64'd0,        "u_zero"};

    ifa.in_valid = 1'b0; ifa.in_kernel = '0; ifa.in_data = '0;
    ifa.in_last  = 1'b0; ifa.in_signed = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_kernel = '0; ifb.in_data = '0;
    ifb.in_last  = 1'b0; ifb.in_signed = 1'b0; ifb.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_a("a_reset");
    chk("b_reset_in_ready",  64'(ifb.in_ready),  64'd1);
    chk("b_reset_out_valid", 64'(ifb.out_valid), 64'd0);
    rst = 1'b0;

    // Single-beat vectors: result, beat count, overflow and latency.
    for (int i = 0; i < 7; i++) begin
      beat_a(vecs[i].k, vecs[i].d, 1'b1, vecs[i].sgn);
      wait_a(1'b1, cyc);
      chk({vecs[i].name, "_latency"},  64'(cyc),              64'd10);
      chk({vecs[i].name, "_result"},   64'(ifa.out_result),   vecs[i].exp);
      chk({vecs[i].name, "_beats"},    64'(ifa.out_beats),    64'd1);
      chk({vecs[i].name, "_overflow"}, 64'(ifa.out_overflow), 64'd0);
      handshake_a();
    end

    // Two beats; in_signed raised on beat 2 must not change the mode.
    beat_a(vecs[0].k, vecs[0].d, 1'b0, 1'b0);
    wait_a(1'b0, cyc);
    chk("two_beat_ready_latency", 64'(cyc),           64'd10);
    chk("two_beat_no_out_valid",  64'(ifa.out_valid), 64'd0);
    beat_a(vecs[0].k, vecs[0].d, 1'b1, 1'b1);
    wait_a(1'b1, cyc);
    chk("two_beat_latency",  64'(cyc),              64'd10);
    chk("two_beat_result",   64'(ifa.out_result),   64'd140);
    chk("two_beat_beats",    64'(ifa.out_beats),    64'd2);
    chk("two_beat_overflow", 64'(ifa.out_overflow), 64'd0);
    handshake_a();

    // Backpressure: result held, new beats refused while out_ready is low.
    beat_a(vecs[0].k, vecs[0].d, 1'b1, 1'b0);
    wait_a(1'b1, cyc);
    chk("bp_latency", 64'(cyc), 64'd10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ifa.in_valid  = 1'b1;
      ifa.in_kernel = 32'hFFFFFFFF;
      ifa.in_data   = 32'hFFFFFFFF;
      ifa.in_last   = 1'b1;
      chk("bp_out_valid", 64'(ifa.out_valid),  64'd1);
      chk("bp_result",    64'(ifa.out_result), 64'd70);
      chk("bp_beats",     64'(ifa.out_beats),  64'd1);
      chk("bp_in_ready",  64'(ifa.in_ready),   64'd0);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("bp_result_after_hold", 64'(ifa.out_result), 64'd70);
    handshake_a();
    repeat (12) @(negedge clk);
    chk("bp_no_phantom_valid", 64'(ifa.out_valid), 64'd0);
    chk("bp_no_phantom_ready", 64'(ifa.in_ready),  64'd1);

    // Overflow on the guard-less engine, then a clean accumulation.
    beat_b(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_b(1'b0, cyc);
    chk("ovf_ready_latency", 64'(cyc), 64'd10);
    beat_b(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_b(1'b1, cyc);
    chk("ovf_latency",  64'(cyc),              64'd10);
    chk("ovf_result",   64'(ifb.out_result),   64'd258056);
    chk("ovf_beats",    64'(ifb.out_beats),    64'd2);
    chk("ovf_flag",     64'(ifb.out_overflow), 64'd1);
    handshake_b();
    chk("ovf_cleared",  64'(ifb.out_overflow), 64'd0);
    beat_b(vecs[0].k, vecs[0].d, 1'b1, 1'b0);
    wait_b(1'b1, cyc);
    chk("post_ovf_latency",  64'(cyc),              64'd10);
    chk("post_ovf_result",   64'(ifb.out_result),   64'd70);
    chk("post_ovf_overflow", 64'(ifb.out_overflow), 64'd0);
    handshake_b();

    // Reset in the middle of a multiply, then a normal accumulation.
    beat_a(vecs[3].k, vecs[3].d, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_a("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    beat_a(vecs[0].k, vecs[0].d, 1'b1, 1'b0);
    wait_a(1'b1, cyc);
    chk("post_reset_latency", 64'(cyc),            64'd10);
    chk("post_reset_result",  64'(ifa.out_result), 64'd70);
    chk("post_reset_beats",   64'(ifa.out_beats),  64'd1);
    handshake_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
